// File: rtl/booth_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : booth_pkg                                                    |
// | Description : Shared types and constants for the booth multiplier arbiter. |
// |               Holds the controller state encoding, operand/product widths  |
// |               and the default watchdog limit.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package booth_pkg;

  localparam int OP_W            = 8;   // operand width on the core bus
  localparam int PROD_W          = 16;  // product width {a,q}
  localparam int DEFAULT_TIMEOUT = 64;  // RUN cycles before a watchdog abort

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_M = 3'd1,
    ST_LOAD_Q = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ABORT  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : booth_arbiter_if                                             |
// | Description : Connection between the arbiter and one booth multiplier core.|
// |   core_rst_b  : active-low core reset        (arbiter -> core)             |
// |   core_bgn    : operand load strobe          (arbiter -> core)             |
// |   core_ibus   : operand bus, m then q        (arbiter -> core)             |
// |   core_stop   : multiplication finished      (core -> arbiter)             |
// |   core_a/q    : product high / low byte      (core -> arbiter)             |
// |   modport master = arbiter side, modport slave = core side.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface booth_arbiter_if;
  import booth_pkg::*;

  logic            core_rst_b;
  logic            core_bgn;
  logic [OP_W-1:0] core_ibus;
  logic            core_stop;
  logic [OP_W-1:0] core_a;
  logic [OP_W-1:0] core_q;

  modport master (
    output core_rst_b, core_bgn, core_ibus,
    input  core_stop, core_a, core_q
  );

  modport slave (
    input  core_rst_b, core_bgn, core_ibus,
    output core_stop, core_a, core_q
  );

endinterface
`default_nettype wire

// File: rtl/booth_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_rr_pick                                                |
// | Description : Combinational round-robin selector. Scans the request vector |
// |               starting at the pointer and wrapping, returns the first hit. |
// |   i_req   : request vector                                                 |
// |   i_ptr   : index where the search starts                                  |
// |   o_gnt   : one-hot winner (zero when nothing is requested)                |
// |   o_valid : a winner exists                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module booth_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_valid
);

  // One extra bit so ptr + offset can exceed NREQ-1 before wrapping.
  localparam int c_sum_w = PTR_W + 1;

  logic [c_sum_w-1:0] w_slot;

  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_slot  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_slot = {1'b0, i_ptr} + c_sum_w'(i);
      if (w_slot >= c_sum_w'(NREQ)) begin
        w_slot = w_slot - c_sum_w'(NREQ);
      end
      if (!o_valid && i_req[w_slot[PTR_W-1:0]]) begin
        o_gnt[w_slot[PTR_W-1:0]] = 1'b1;
        o_valid                  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_arbiter                                                |
// | Description : Shares one booth multiplier core among NREQ requesters.      |
// |               Grants round-robin, loads multiplicand then multiplier with  |
// |               bgn high, waits for stop and returns {a,q} to the owner.     |
// |   clk, rst_b     : clock, asynchronous active-low reset                    |
// |   req            : per-requester request                                   |
// |   m_in / q_in    : flattened 8-bit operands, slice i for requester i       |
// |   gnt / done     : one-hot owner / one-cycle completion pulse              |
// |   product        : captured {a,q}, held until the next capture             |
// |   err            : watchdog abort pulse                                    |
// |   core           : core bus (booth_arbiter_if.master)                      |
// | Build option: BOOTH_ARB_TIMEOUT_EN enables the RUN watchdog, which aborts  |
// |               and resets a core that has not raised stop after TIMEOUT     |
// |               RUN cycles.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*OP_W-1:0] m_in,
  input  logic [NREQ*OP_W-1:0] q_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [PROD_W-1:0]    product,
  output logic                 err,
  booth_arbiter_if.master      core
);

  localparam int c_ptr_w = $clog2(NREQ);

  // The watchdog counter is 8 bits wide, so the limit must fit in 1..256.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_param_check
    $error("booth_arbiter: NREQ must be 2..8 and TIMEOUT 1..256");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NREQ-1:0]     r_gnt;
  logic [c_ptr_w-1:0]  r_ptr;
  logic [c_ptr_w-1:0]  w_ptr_nxt;
  logic [OP_W-1:0]     r_m;
  logic [OP_W-1:0]     r_q;
  logic [OP_W-1:0]     w_m_sel;
  logic [OP_W-1:0]     w_q_sel;
  logic [PROD_W-1:0]   r_product;
  logic                r_core_rst_b;
  logic [NREQ-1:0]     w_pick;
  logic                w_pick_valid;
  logic                w_bgn;
  logic [OP_W-1:0]     w_ibus;
  logic                w_fin;

  booth_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_ptr_w)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick),
    .o_valid (w_pick_valid)
  );

  // Operand slices of the winner and the pointer value that follows it.
  always_comb begin
    w_m_sel   = '0;
    w_q_sel   = '0;
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_m_sel   = m_in[i*OP_W +: OP_W];
        w_q_sel   = q_in[i*OP_W +: OP_W];
        w_ptr_nxt = (i == NREQ - 1) ? '0 : c_ptr_w'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  // Held at zero outside RUN, so every RUN entry starts counting from zero.
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign err = (r_state == ST_ABORT);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_bgn       = 1'b0;
    w_ibus      = '0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_state_nxt = ST_LOAD_M;
      end
      ST_LOAD_M: begin
        w_bgn       = 1'b1;
        w_ibus      = r_m;
        w_state_nxt = ST_LOAD_Q;
      end
      ST_LOAD_Q: begin
        w_bgn       = 1'b1;
        w_ibus      = r_q;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (core.core_stop) begin
          w_state_nxt = ST_DONE;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (r_cnt == c_cnt_last) begin
          w_state_nxt = ST_ABORT;
        end
`endif
      end
      ST_DONE, ST_ABORT: begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_gnt        <= '0;
      r_ptr        <= '0;
      r_m          <= '0;
      r_q          <= '0;
      r_product    <= '0;
      r_core_rst_b <= 1'b0;
    end else begin
      r_core_rst_b <= 1'b1;
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_gnt <= w_pick;
        r_m   <= w_m_sel;
        r_q   <= w_q_sel;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_RUN && core.core_stop) begin
        r_product <= {core.core_a, core.core_q};
      end
`ifdef BOOTH_ARB_TIMEOUT_EN
      // Aborting: zero the result and hold the core in reset for the
      // single ABORT cycle.
      if (r_state == ST_RUN && w_state_nxt == ST_ABORT) begin
        r_product    <= '0;
        r_core_rst_b <= 1'b0;
      end
`endif
      if (w_fin) begin
        r_gnt <= '0;
      end
    end
  end

  assign gnt             = r_gnt;
  assign done            = w_fin ? r_gnt : '0;
  assign product         = r_product;
  assign core.core_rst_b = r_core_rst_b;
  assign core.core_bgn   = w_bgn;
  assign core.core_ibus  = w_ibus;

endmodule
`default_nettype wire

// File: doc/booth_arbiter.md
# booth_arbiter

Round-robin controller that shares one `booth` multiplier core among `NREQ` requesters. It picks one pending request and sequences the core's operand-load protocol: `bgn` with multiplicand, then multiplier, on `ibus`. It then waits for `stop`, captures the 16-bit product from the core's `a`/`q` outputs and returns it to the granted requester. An optional watchdog aborts and resets a hung core.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum RUN cycles before abort (watchdog build only).
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester request; held high until its `done`.
- `m_in` in NREQ*8: flattened multiplicands; slice i belongs to requester i; two's complement.
- `q_in` in NREQ*8: flattened multipliers; same slicing; two's complement.
- `gnt` out NREQ: one-hot owner of the core; 0 when idle.
- `done` out NREQ: one-cycle completion pulse to the owner.
- `product` out 16: signed result `{a,q}`; valid while `done` is high, held until the next capture.
- `err` out 1: one-cycle pulse when a watchdog abort occurs.
- `core_rst_b` out 1: registered active-low reset to the core.
- `core_bgn` out 1: core `bgn`.
- `core_ibus` out 8: core `ibus`.
- `core_stop` in 1: core `stop`.
- `core_a` in 8: core accumulator, product high byte.
- `core_q` in 8: core Q register, product low byte.

## Operation
- States: IDLE, LOAD_M, LOAD_Q, RUN, DONE, ABORT.
- IDLE: `core_bgn`=0, `core_ibus`=0. If any `req` is high, select the winner round-robin, set `gnt`, latch its `m_in`/`q_in` slices, and go to LOAD_M.
- LOAD_M: `core_bgn`=1, `core_ibus`=latched multiplicand. Go to LOAD_Q.
- LOAD_Q: `core_bgn`=1, `core_ibus`=latched multiplier. Go to RUN.
- RUN: `core_bgn`=0, `core_ibus`=0. On `core_stop`=1, capture `{core_a,core_q}` into `product` and go to DONE.
- DONE: pulse `done[g]`. Clear `gnt` and go to IDLE.
- ABORT: pulse `err`, drive `core_rst_b`=0 for one cycle, set `product`=0, pulse `done[g]`, clear `gnt`, return to IDLE.
- Round-robin pointer: 0 after reset. The search starts at the pointer; after a grant to g the pointer becomes (g+1) mod NREQ.
- Operands are latched at grant, so requester changes after grant are ignored.
- If `req[g]` drops mid-operation, the operation still completes and `done[g]` still pulses.
- A `req` still high in the cycle after `done` counts as a new request and is arbitrated normally behind the other requesters.

## Timing
- Reset values:
  - state IDLE, `gnt`=0, `done`=0, `product`=0, `err`=0.
  - `core_bgn`=0, `core_ibus`=0, pointer 0.
  - `core_rst_b`=0 while `rst_b` is low; 1 from the first clock edge after release.
- Latency: `req` sampled in IDLE at cycle 0 gives `core_bgn` high in cycles 1–2. If `core_stop` is seen in cycle k, `done` pulses in cycle k+1.
- Minimum gap between grants is one IDLE cycle.
- `core_stop` is ignored outside RUN.
- Reset mid-operation: all state returns immediately to reset values and no `done` is issued. `core_rst_b` asserts asynchronously.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined:
  - An 8-bit RUN cycle counter is enabled.
  - The counter clears on RUN entry.
  - When it reaches `TIMEOUT` without `core_stop`, the FSM enters ABORT.
- `BOOTH_ARB_TIMEOUT_EN` undefined:
  - There is no counter or ABORT state.
  - RUN waits indefinitely.
  - `err` is tied to 0 and `core_rst_b` follows reset only.

## Structure
- Package `booth_pkg` holds:
  - the state enum;
  - `OP_W`=8 and `PROD_W`=16;
  - the default `TIMEOUT`.
- Sub-module `booth_rr_pick`: combinational round-robin selector taking `req` and the pointer, and producing a one-hot grant plus a valid flag.
- The FSM, operand latches, product register and watchdog live in `booth_arbiter`.

## Test plan
- Requester 0 with m=2, q=3, core behavioral model → `core_ibus` shows 2 then 3 with `bgn` high; `product`=0x0006 with `done[0]`.
- Requester 1 with m=-5 (0xFB), q=7 → `product`=0xFFDD (-35); `gnt`=0b0010 throughout.
- `req[0]` and `req[2]` asserted together and held → grants go 0, 2, 0, 2; each `done` is a one-cycle pulse to the correct requester.
- Watchdog build, core model never raises `stop`, TIMEOUT=64 → 64 RUN cycles, then `err`=1 and `core_rst_b`=0 for one cycle, `product`=0, `done[g]` pulses, FSM back to IDLE.
- `rst_b` pulsed low during RUN → `gnt`=0, `core_bgn`=0, `product`=0 immediately; no `done`; next request proceeds normally from pointer 0.
- `req[3]` dropped during RUN → `done[3]` still pulses with the correct product; no spurious re-grant to requester 3.
